// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB3 master bridge.
// Holds the FSM state encoding, the default PREADY watchdog limit and the full-word strobe value.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam int         TIMEOUT_CYCLES_DEF = 255;
   localparam logic [3:0] BE_FULL            = 4'hF;

endpackage

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid data port to single APB3 master transfers.
// A PREADY watchdog turns a hung slave into an error response.
module apb_master_bridge
   import apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      data_req_i,
   input  logic [31:0]               data_addr_i,
   input  logic                      data_we_i,
   input  logic [3:0]                data_be_i,
   input  logic [31:0]               data_wdata_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   output logic [31:0]               data_rdata_o,
   output logic                      data_err_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   apb_state_e                r_state;
   apb_state_e                w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          w_cnt_inc;
   logic                      w_timeout;
   logic                      w_bad_be;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [31:0]               r_pwdata;
   logic                      r_pwrite;
   logic [31:0]               r_rdata;
   logic                      r_err;
   logic                      w_addr_unused;

   // Upper address bits are decoded upstream; byte offset is dropped for word access.
   assign w_addr_unused = ^{data_addr_i[31:APB_ADDR_WIDTH], data_addr_i[1:0]};

   // APB3 has no write strobes, so partial writes are refused without a bus cycle.
   assign w_bad_be  = data_we_i && (data_be_i != BE_FULL);
   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (data_req_i) w_state_nxt = w_bad_be ? RESP : SETUP;
         end
         SETUP:  w_state_nxt = ACCESS;
         ACCESS: begin
            if (PREADY) begin
               w_state_nxt = RESP;
            end else if (TO_EN && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
               w_timeout   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pwrite <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ACCESS) && (w_state_nxt == ACCESS)) r_cnt <= w_cnt_inc;
         else                                               r_cnt <= '0;

         if ((r_state == IDLE) && data_req_i) begin
            r_paddr  <= {data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
            r_pwdata <= data_wdata_i;
            r_pwrite <= data_we_i;
            if (w_bad_be) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end

         if ((r_state == ACCESS) && PREADY) begin
            r_rdata <= r_pwrite ? 32'h0 : PRDATA;
            r_err   <= PSLVERR;
         end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end

   // Reset gating keeps gnt low while HRESETn is asserted.
   assign data_gnt_o    = (r_state == IDLE) && data_req_i && HRESETn;
   assign data_rvalid_o = (r_state == RESP);
   assign data_rdata_o  = r_rdata;
   assign data_err_o    = r_err;
   assign PADDR         = r_paddr;
   assign PWDATA        = r_pwdata;
   assign PWRITE        = r_pwrite;
   assign PSEL          = (r_state == SETUP) || (r_state == ACCESS);
   assign PENABLE       = (r_state == ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a cycle-indexed transaction model plus a
// reactive APB slave, checked every cycle, with literal latency/data pins per test.
module tb_apb_master_bridge;

   localparam int T = 4;
   localparam int N = 1024;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        data_req_i = 1'b0;
   logic [31:0] data_addr_i = '0;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE, PSEL, PENABLE;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;

   apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(T)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   // Expected bus/response activity, indexed by cycle number
   bit          e_psel[N], e_pen[N], e_rv[N], e_busy[N], e_pwrite[N], e_err[N];
   logic [11:0] e_paddr[N];
   logic [31:0] e_pwdata[N], e_rdata[N];
   logic [31:0] last_rdata = '0;
   bit          last_err = 1'b0;
   int          cur_end = 0;

   int n_chk = 0;
   int n_fail = 0;

   int          sl_waits = 0;
   logic [31:0] sl_prdata = '0;
   bit          sl_err = 1'b0;
   int          acc_n = 0;

   int          obs_psel = -1, obs_rv = -1;
   logic [11:0] obs_paddr = '0;
   logic [31:0] obs_rdata = '0;
   bit          obs_err = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Slave: PREADY rises after sl_waits ACCESS cycles; junk on PRDATA while not ready
   always @(negedge HCLK) begin
      if (PSEL && PENABLE) begin
         PREADY  = (acc_n == sl_waits);
         PRDATA  = PREADY ? sl_prdata : (32'h0BAD0BAD ^ acc_n);
         PSLVERR = PREADY ? sl_err : 1'b1;
         acc_n++;
      end else begin
         acc_n   = 0;
         PREADY  = 1'b0;
         PRDATA  = '0;
         PSLVERR = 1'b0;
      end
   end

   always @(negedge HCLK) begin
      #2;
      if (cyc < N) begin
         chk("gnt",     data_gnt_o,    data_req_i && HRESETn && !e_busy[cyc]);
         chk("psel",    PSEL,          e_psel[cyc]);
         chk("penable", PENABLE,       e_pen[cyc]);
         chk("rvalid",  data_rvalid_o, e_rv[cyc]);
         if (e_psel[cyc]) begin
            chk("paddr",  PADDR,  e_paddr[cyc]);
            chk("pwrite", PWRITE, e_pwrite[cyc]);
            chk("pwdata", PWDATA, e_pwdata[cyc]);
         end
         if (e_rv[cyc]) begin
            last_rdata = e_rdata[cyc];
            last_err   = e_err[cyc];
         end
         chk("rdata", data_rdata_o, last_rdata);
         chk("err",   data_err_o,   last_err);
      end
      if (PSEL && obs_psel < 0) begin
         obs_psel  = cyc;
         obs_paddr = PADDR;
      end
      if (data_rvalid_o && obs_rv < 0) begin
         obs_rv    = cyc;
         obs_rdata = data_rdata_o;
         obs_err   = data_err_o;
      end
   end

   task automatic do_txn(input logic [31:0] addr, input bit we, input logic [3:0] be,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] prdata, input bit serr, output int g);
      int n;
      bit to;
      g = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge HCLK);
         data_req_i = 1'b1; data_addr_i = addr; data_we_i = we;
         data_be_i = be; data_wdata_i = wdata;
         #1;
         if (data_gnt_o) begin
            g = cyc;
            break;
         end
      end
      if (g < 0) begin
         n_chk++; n_fail++;
         $display("FAIL grant_wait: got no gnt expected gnt within 50 cycles");
         return;
      end
      obs_psel = -1; obs_rv = -1;
      sl_waits = waits; sl_prdata = prdata; sl_err = serr;
      if (we && be != 4'hF) begin
         e_busy[g+1] = 1; e_rv[g+1] = 1; e_rdata[g+1] = 0; e_err[g+1] = 1;
         cur_end = g + 1;
      end else begin
         to = (waits >= T);
         n  = to ? T : waits + 1;
         for (int c = g + 1; c <= g + 1 + n; c++) begin
            e_busy[c] = 1; e_psel[c] = 1; e_pen[c] = (c >= g + 2);
            e_paddr[c] = 12'((addr % 4096) / 4 * 4);
            e_pwrite[c] = we; e_pwdata[c] = wdata;
         end
         e_busy[g+2+n] = 1; e_rv[g+2+n] = 1;
         e_rdata[g+2+n] = (to || we) ? 32'h0 : prdata;
         e_err[g+2+n]   = to ? 1'b1 : serr;
         cur_end = g + 2 + n;
      end
   endtask

   task automatic wait_done();
      @(negedge HCLK);
      data_req_i = 1'b0;
      for (int k = 0; k < 60 && cyc <= cur_end; k++) @(negedge HCLK);
      if (cyc <= cur_end) begin
         n_chk++; n_fail++;
         $display("FAIL done_wait: got cycle %0d expected past %0d", cyc, cur_end);
      end
      #3;
   endtask

   initial begin
      int g, g2;
      #1 HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      #3;
      chk("rst_psel", PSEL, 0);
      chk("rst_rvalid", data_rvalid_o, 0);
      HRESETn = 1'b1;

      // Zero-wait read
      do_txn(32'h0000_0004, 0, 4'h0, 32'h0, 0, 32'hDEADBEEF, 0, g);
      wait_done();
      chk("rd_psel_lat", obs_psel - g, 1);
      chk("rd_paddr", obs_paddr, 12'h004);
      chk("rd_rv_lat", obs_rv - g, 3);
      chk("rd_rdata", obs_rdata, 32'hDEADBEEF);
      chk("rd_err", obs_err, 0);

      // Write with 3 wait states
      do_txn(32'h0000_0010, 1, 4'hF, 32'h12345678, 3, 32'h0, 0, g);
      wait_done();
      chk("wr_rv_lat", obs_rv - g, 6);
      chk("wr_err", obs_err, 0);
      chk("wr_rdata", obs_rdata, 0);

      // Partial-strobe write is refused without bus activity
      do_txn(32'h0000_0020, 1, 4'h3, 32'hAAAA5555, 0, 32'h0, 0, g);
      wait_done();
      chk("be_psel_never", obs_psel, 32'hFFFFFFFF);
      chk("be_rv_lat", obs_rv - g, 1);
      chk("be_err", obs_err, 1);

      // Slave error on a read
      do_txn(32'h0000_0008, 0, 4'h0, 32'h0, 1, 32'h13572468, 1, g);
      wait_done();
      chk("slverr_err", obs_err, 1);

      // Watchdog expiry, then a fresh request with upper/lower address bits set
      do_txn(32'h0000_0030, 0, 4'hF, 32'h0, 1000, 32'h55555555, 0, g);
      wait_done();
      chk("to_rv_lat", obs_rv - g, 2 + T);
      chk("to_err", obs_err, 1);
      chk("to_rdata", obs_rdata, 0);
      do_txn(32'hABCD_1013, 0, 4'h0, 32'h0, 2, 32'hCAFE0001, 0, g);
      wait_done();
      chk("post_to_paddr", obs_paddr, 12'h010);
      chk("post_to_rdata", obs_rdata, 32'hCAFE0001);

      // Reset pulsed in ACCESS aborts the transfer silently
      do_txn(32'h0000_0040, 0, 4'h0, 32'h0, 100, 32'h11111111, 0, g);
      @(negedge HCLK); data_req_i = 1'b0;
      @(negedge HCLK);
      #3;
      HRESETn = 1'b0;
      for (int c = cyc + 1; c < N; c++) begin
         e_psel[c] = 0; e_pen[c] = 0; e_rv[c] = 0; e_busy[c] = 0;
      end
      last_rdata = '0; last_err = 1'b0;
      #1;
      chk("rst_mid_psel", PSEL, 0);
      chk("rst_mid_penable", PENABLE, 0);
      repeat (2) @(negedge HCLK);
      #3 HRESETn = 1'b1;
      repeat (6) @(negedge HCLK);
      #3;
      chk("rst_mid_no_rv", obs_rv, 32'hFFFFFFFF);
      do_txn(32'h0000_0044, 0, 4'h0, 32'h0, 0, 32'h0F0F0F0F, 0, g);
      wait_done();
      chk("after_rst_rv_lat", obs_rv - g, 3);
      chk("after_rst_rdata", obs_rdata, 32'h0F0F0F0F);

      // Back-to-back: request held during busy is granted at the next IDLE
      do_txn(32'h0000_0050, 1, 4'hF, 32'hFEEDFACE, 0, 32'h0, 0, g);
      do_txn(32'h0000_0054, 0, 4'h0, 32'h0, 1, 32'h2468ACE0, 0, g2);
      wait_done();
      chk("held_gnt_gap", g2 - g, 4);
      chk("held_rdata", obs_rdata, 32'h2468ACE0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
